multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM that sequences the 64-bit multi-cycle RISC-V datapath. It decodes the instruction register contents and the ALU zero flag, and drives every datapath select and enable so that each instruction completes in 3–5 cycles. The datapath holds the architectural state; this block holds only the state register.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- inst  in  32  instruction register contents (opcode [6:0], funct3 [14:12], funct7[5] = bit 30)
- zero  in  1  ALU zero flag (combinational from datapath)
- pcen  out  1  PC write enable
- IorD  out  1  memory address select: 0 = PC, 1 = ALU_Out
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- MemtoReg  out  2  writeback select: 0 = ALU_Out, 1 = MDR, 2 = PC, 3 = sign-extended MDR[31:0]
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU B select: 0 = B, 1 = 4, 2 = immediate, 3 = ALU_Out
- PCSrc  out  1  PC source: 0 = ALU result, 1 = ALU_Out
- sw  out  1  store data select: 1 = sign-extended B[31:0] (word), 0 = B (doubleword)
- alu_ctrl  out  4  ALU operation: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111
- halted  out  1  high in HALT state; tied 0 when the trap feature is compiled out

## Operation
State register is 4 bits and is the only storage. Any output not listed for a state is 0. alu_ctrl defaults to ADD.

States and behaviour:
- FETCH: IorD=0, MemRead=1, IRWrite=1. Outputs do not depend on `inst`, which is stale in this state. Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=2, ADD, so ALU_Out = PC + imm. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADR
  - 1100011 -> BRANCH
  - 1101111 -> JUMP
  - 1100111 -> JALR_ADR
  - any other opcode -> ILLEGAL path
- EXEC_R: ALUSrcA=1, ALUSrcB=0. funct3 000 -> ADD, or SUB if funct7[5]=1; 111 -> AND; 110 -> OR; 100 -> XOR; 010 -> SLT; any other funct3 -> ADD. Next state: ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=2. Same funct3 map, but funct7 is ignored (000 always ADD). Next state: ALU_WB.
- ALU_WB: MemtoReg=0, RegWrite=1, ALUSrcA=0, ALUSrcB=1, ADD, PCSrc=0, pcen=1 (PC <= PC+4). Next state: FETCH.
- MEM_ADR: ALUSrcA=1, ALUSrcB=2, ADD. Next state: MEM_RD for a load, MEM_WR for a store.
- MEM_RD: IorD=1, MemRead=1. ALU repeats A+imm so ALU_Out holds the address. Next state: MEM_WB.
- MEM_WB: RegWrite=1; MemtoReg=3 when funct3=010 (lw), else 1 (ld). PC <= PC+4 as in ALU_WB. Next state: FETCH.
- MEM_WR: IorD=1, MemWrite=1; sw = (funct3==010). PC <= PC+4 as in ALU_WB. Next state: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, SUB. Taken = zero for funct3 000 (beq), !zero for funct3 001 (bne), 0 for any other funct3.
  - Taken: pcen=1, PCSrc=1; next state FETCH.
  - Not taken: next state PC_INC.
- PC_INC: ALUSrcA=0, ALUSrcB=1, ADD, PCSrc=0, pcen=1. Next state: FETCH.
- JALR_ADR: ALUSrcA=1, ALUSrcB=2, ADD. Next state: JUMP.
- JUMP: PCSrc=1, pcen=1 (PC <= ALU_Out target). ALUSrcA=0, ALUSrcB=1, ADD, so ALU_Out <= old PC+4. Next state: LINK_WB.
- LINK_WB: MemtoReg=0, RegWrite=1. Next state: FETCH.
- HALT: see Configuration.

## Timing
- Reset: state forced to FETCH asynchronously while rst is high. Outputs during and after reset are the FETCH values: MemRead=1, IRWrite=1, IorD=0, all other outputs 0, halted=0.
- Reset mid-instruction: the current state is abandoned immediately; no further write enable from that instruction is asserted.
- Outputs are combinational from state and `inst`. pcen in BRANCH also depends on `zero` (Mealy path).
- Cycles per instruction, FETCH through last state:
  - R-type, I-type, store, jal: 4
  - load, jalr: 5
  - branch taken: 3; not taken: 4
- At most one of MemRead and MemWrite is high in any cycle.
- RegWrite and pcen may both be high in the same cycle.

## Configuration
- ILLEGAL_TRAP_EN defined: the ILLEGAL path enters HALT.
  - In HALT: halted=1, all enables and strobes 0.
  - HALT is left only by rst.
- ILLEGAL_TRAP_EN undefined: the ILLEGAL path enters PC_INC, so the instruction acts as a 3-cycle NOP. halted is tied 0 and HALT is unreachable.

## Test plan
- Reset: assert rst during MEM_RD -> same cycle MemRead=1, IRWrite=1, IorD=0, pcen=0, RegWrite=0; after release, next state DECODE.
- add/sub: inst=0x002081B3 -> EXEC_R alu_ctrl=0010. Then ALU_WB RegWrite=1, pcen=1, PCSrc=0. 4 cycles total. inst=0x402081B3 -> alu_ctrl=0110.
- Load: inst=0x0080A283 (lw x5,8(x1)) -> MEM_RD IorD=1, MemRead=1. MEM_WB MemtoReg=3, RegWrite=1, pcen=1. 5 cycles total.
- Store: inst=0x0050B823 (sd x5,16(x1)) -> MEM_WR MemWrite=1, IorD=1, sw=0, pcen=1. 4 cycles total.
- Branch: inst=0x00208463 (beq):
  - zero=1 in BRANCH -> alu_ctrl=0110, pcen=1, PCSrc=1, next FETCH.
  - zero=0 -> pcen=0, then PC_INC pcen=1, PCSrc=0.
- Illegal: inst=0xFFFFFFFF:
  - With ILLEGAL_TRAP_EN -> HALT, halted=1, all enables 0 for 20+ cycles.
  - Without -> PC_INC, pcen=1, then FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the 64-bit multi-cycle RISC-V datapath; the 4-bit state register is its only storage.
// Optional feature macro ILLEGAL_TRAP_EN: unknown opcodes halt the core instead of executing as a NOP.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        zero,
    output logic        pcen,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        PCSrc,
    output logic        sw,
    output logic [3:0]  alu_ctrl,
    output logic        halted
);
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB,
        MEM_WR, BRANCH, PC_INC, JALR_ADR, JUMP, LINK_WB, HALT
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t     state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       br_taken;
    logic       unused_inst;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign funct7_5    = inst[30];
    assign unused_inst = &{1'b0, inst[31], inst[29:15], inst[11:7]};

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub_en);
        case (f3)
            3'b000:  alu_decode = sub_en ? ALU_SUB : ALU_ADD;
            3'b111:  alu_decode = ALU_AND;
            3'b110:  alu_decode = ALU_OR;
            3'b100:  alu_decode = ALU_XOR;
            3'b010:  alu_decode = ALU_SLT;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    // Only beq and bne are supported; other branch encodings fall through.
    assign br_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_R:              state <= EXEC_R;
                        OP_I:              state <= EXEC_I;
                        OP_LOAD, OP_STORE: state <= MEM_ADR;
                        OP_BR:             state <= BRANCH;
                        OP_JAL:            state <= JUMP;
                        OP_JALR:           state <= JALR_ADR;
`ifdef ILLEGAL_TRAP_EN
                        default:           state <= HALT;
`else
                        default:           state <= PC_INC;
`endif
                    endcase
                end
                EXEC_R, EXEC_I: state <= ALU_WB;
                MEM_ADR:  state <= (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
                MEM_RD:   state <= MEM_WB;
                BRANCH:   state <= br_taken ? FETCH : PC_INC;
                JALR_ADR: state <= JUMP;
                JUMP:     state <= LINK_WB;
                HALT:     state <= HALT;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        pcen     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = 2'd0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'd0;
        PCSrc    = 1'b0;
        sw       = 1'b0;
        alu_ctrl = ALU_ADD;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
            end
            DECODE: ALUSrcB = 2'd2;
            EXEC_R: begin
                ALUSrcA  = 1'b1;
                alu_ctrl = alu_decode(funct3, funct7_5);
            end
            EXEC_I: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'd2;
                alu_ctrl = alu_decode(funct3, 1'b0);
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                ALUSrcB  = 2'd1;
                pcen     = 1'b1;
            end
            MEM_ADR, JALR_ADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            // Recompute A+imm so ALU_Out keeps holding the load address.
            MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (funct3 == 3'b010) ? 2'd3 : 2'd1;
                ALUSrcB  = 2'd1;
                pcen     = 1'b1;
            end
            MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                sw       = (funct3 == 3'b010);
                ALUSrcB  = 2'd1;
                pcen     = 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                alu_ctrl = ALU_SUB;
                pcen     = br_taken;
                PCSrc    = br_taken;
            end
            PC_INC: begin
                ALUSrcB = 2'd1;
                pcen    = 1'b1;
            end
            // PC takes the target latched in ALU_Out while the ALU forms the link value PC+4.
            JUMP: begin
                PCSrc   = 1'b1;
                pcen    = 1'b1;
                ALUSrcB = 2'd1;
            end
            LINK_WB: RegWrite = 1'b1;
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected per-cycle control vectors are queued per instruction.
module tb_multicycle_controller;
    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_XOR = 4'b0011;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        zero;
    logic        pcen, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, PCSrc, sw, halted;
    logic [1:0]  MemtoReg, ALUSrcB;
    logic [3:0]  alu_ctrl;
    logic [17:0] outv;
    logic [17:0] sb[$];
    int          n_cmp = 0;
    int          n_err = 0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .inst(inst), .zero(zero),
        .pcen(pcen), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .sw(sw),
        .alu_ctrl(alu_ctrl), .halted(halted)
    );

    always #5 clk = ~clk;

    assign outv = {pcen, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, PCSrc, sw, alu_ctrl, halted};

    function automatic logic [17:0] mk(input logic pc, iord, mr, mw, irw, input logic [1:0] m2r,
                                       input logic rw, sa, input logic [1:0] sbv,
                                       input logic pcs, swv, input logic [3:0] alu, input logic h);
        return {pc, iord, mr, mw, irw, m2r, rw, sa, sbv, pcs, swv, alu, h};
    endfunction

    function automatic logic [17:0] v_fetch();    return mk(0,0,1,0,1,2'd0,0,0,2'd0,0,0,A_ADD,0); endfunction
    function automatic logic [17:0] v_decode();   return mk(0,0,0,0,0,2'd0,0,0,2'd2,0,0,A_ADD,0); endfunction
    function automatic logic [17:0] v_exec_r(input logic [3:0] a); return mk(0,0,0,0,0,2'd0,0,1,2'd0,0,0,a,0); endfunction
    function automatic logic [17:0] v_exec_i(input logic [3:0] a); return mk(0,0,0,0,0,2'd0,0,1,2'd2,0,0,a,0); endfunction
    function automatic logic [17:0] v_alu_wb();   return mk(1,0,0,0,0,2'd0,1,0,2'd1,0,0,A_ADD,0); endfunction
    function automatic logic [17:0] v_a_imm();    return mk(0,0,0,0,0,2'd0,0,1,2'd2,0,0,A_ADD,0); endfunction
    function automatic logic [17:0] v_mem_rd();   return mk(0,1,1,0,0,2'd0,0,1,2'd2,0,0,A_ADD,0); endfunction
    function automatic logic [17:0] v_mem_wb(input logic [1:0] m); return mk(1,0,0,0,0,m,1,0,2'd1,0,0,A_ADD,0); endfunction
    function automatic logic [17:0] v_mem_wr(input logic s); return mk(1,1,0,1,0,2'd0,0,0,2'd1,0,s,A_ADD,0); endfunction
    function automatic logic [17:0] v_branch(input logic t); return mk(t,0,0,0,0,2'd0,0,1,2'd0,t,0,A_SUB,0); endfunction
    function automatic logic [17:0] v_pc_inc();   return mk(1,0,0,0,0,2'd0,0,0,2'd1,0,0,A_ADD,0); endfunction
    function automatic logic [17:0] v_jump();     return mk(1,0,0,0,0,2'd0,0,0,2'd1,1,0,A_ADD,0); endfunction
    function automatic logic [17:0] v_link_wb();  return mk(0,0,0,0,0,2'd0,1,0,2'd0,0,0,A_ADD,0); endfunction
    function automatic logic [17:0] v_halt();     return mk(0,0,0,0,0,2'd0,0,0,2'd0,0,0,A_ADD,1); endfunction

    task automatic test_reset();
        logic [17:0] exp;
        rst = 1'b1; inst = 32'h0; zero = 1'b0;
        #1;
        n_cmp++;
        if (outv !== v_fetch()) begin
            n_err++; $display("FAIL reset_async got=%b want=%b", outv, v_fetch());
        end
        @(negedge clk);
        n_cmp++;
        if (outv !== v_fetch()) begin
            n_err++; $display("FAIL reset_held got=%b want=%b", outv, v_fetch());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        inst = 32'h002081B3;
        sb.push_back(v_fetch()); sb.push_back(v_decode());
        sb.push_back(v_exec_r(A_ADD)); sb.push_back(v_alu_wb());
        while (sb.size() != 0) begin
            exp = sb.pop_front();
            @(negedge clk);
            n_cmp++;
            if (outv !== exp) begin
                n_err++; $display("FAIL reset_release got=%b want=%b", outv, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_r_type();
        logic [31:0] insts[7] = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                                  32'h0020C1B3, 32'h0020A1B3, 32'h002091B3};
        logic [3:0]  alus[7]  = '{A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLT, A_ADD};
        logic [17:0] exp;
        for (int i = 0; i < 7; i++) begin
            inst = insts[i];
            sb.push_back(v_fetch()); sb.push_back(v_decode());
            sb.push_back(v_exec_r(alus[i])); sb.push_back(v_alu_wb());
            while (sb.size() != 0) begin
                exp = sb.pop_front();
                @(negedge clk);
                n_cmp++;
                if (outv !== exp) begin
                    n_err++; $display("FAIL r_type inst=%h got=%b want=%b", inst, outv, exp);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_i_type();
        logic [31:0] insts[5] = '{32'h40008193, 32'h0FF0F193, 32'h0FF0E193, 32'h0FF0C193, 32'h0FF0A193};
        logic [3:0]  alus[5]  = '{A_ADD, A_AND, A_OR, A_XOR, A_SLT};
        logic [17:0] exp;
        for (int i = 0; i < 5; i++) begin
            inst = insts[i];
            sb.push_back(v_fetch()); sb.push_back(v_decode());
            sb.push_back(v_exec_i(alus[i])); sb.push_back(v_alu_wb());
            while (sb.size() != 0) begin
                exp = sb.pop_front();
                @(negedge clk);
                n_cmp++;
                if (outv !== exp) begin
                    n_err++; $display("FAIL i_type inst=%h got=%b want=%b", inst, outv, exp);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_mem();
        logic [17:0] exp;
        // lw, ld, sw, sd
        logic [31:0] insts[4] = '{32'h0080A283, 32'h0080B283, 32'h0050A823, 32'h0050B823};
        for (int i = 0; i < 4; i++) begin
            inst = insts[i];
            sb.push_back(v_fetch()); sb.push_back(v_decode()); sb.push_back(v_a_imm());
            case (i)
                0: begin sb.push_back(v_mem_rd()); sb.push_back(v_mem_wb(2'd3)); end
                1: begin sb.push_back(v_mem_rd()); sb.push_back(v_mem_wb(2'd1)); end
                2: sb.push_back(v_mem_wr(1'b1));
                default: sb.push_back(v_mem_wr(1'b0));
            endcase
            while (sb.size() != 0) begin
                exp = sb.pop_front();
                @(negedge clk);
                n_cmp++;
                if (outv !== exp) begin
                    n_err++; $display("FAIL mem inst=%h got=%b want=%b", inst, outv, exp);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] insts[6] = '{32'h00208463, 32'h00208463, 32'h00209463,
                                  32'h00209463, 32'h0020C463, 32'h0020C463};
        logic        zs[6]    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        tk[6]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [17:0] exp;
        for (int i = 0; i < 6; i++) begin
            inst = insts[i]; zero = zs[i];
            sb.push_back(v_fetch()); sb.push_back(v_decode()); sb.push_back(v_branch(tk[i]));
            if (!tk[i]) sb.push_back(v_pc_inc());
            while (sb.size() != 0) begin
                exp = sb.pop_front();
                @(negedge clk);
                n_cmp++;
                if (outv !== exp) begin
                    n_err++; $display("FAIL branch inst=%h zero=%b got=%b want=%b", inst, zero, outv, exp);
                end
                @(posedge clk); #1;
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [17:0] exp;
        inst = 32'h008000EF;
        sb.push_back(v_fetch()); sb.push_back(v_decode()); sb.push_back(v_jump()); sb.push_back(v_link_wb());
        sb.push_back(v_fetch());
        while (sb.size() != 0) begin
            exp = sb.pop_front();
            @(negedge clk);
            n_cmp++;
            if (outv !== exp) begin
                n_err++; $display("FAIL jal got=%b want=%b", outv, exp);
            end
            @(posedge clk); #1;
            if (sb.size() == 0) break;
            if (sb.size() == 1) inst = 32'h000080E7;
        end
        // jalr enters here already past its FETCH cycle
        sb.push_back(v_decode()); sb.push_back(v_a_imm()); sb.push_back(v_jump()); sb.push_back(v_link_wb());
        while (sb.size() != 0) begin
            exp = sb.pop_front();
            @(negedge clk);
            n_cmp++;
            if (outv !== exp) begin
                n_err++; $display("FAIL jalr got=%b want=%b", outv, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] exp;
        inst = 32'h0080A283;
        sb.push_back(v_fetch()); sb.push_back(v_decode()); sb.push_back(v_a_imm());
        while (sb.size() != 0) begin
            exp = sb.pop_front();
            @(negedge clk);
            n_cmp++;
            if (outv !== exp) begin
                n_err++; $display("FAIL reset_mid_pre got=%b want=%b", outv, exp);
            end
            @(posedge clk); #1;
        end
        #2;
        n_cmp++;
        if (outv !== v_mem_rd()) begin
            n_err++; $display("FAIL reset_mid_memrd got=%b want=%b", outv, v_mem_rd());
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (outv !== v_fetch()) begin
            n_err++; $display("FAIL reset_mid_same_cycle got=%b want=%b", outv, v_fetch());
        end
        @(posedge clk); #1;
        n_cmp++;
        if (outv !== v_fetch()) begin
            n_err++; $display("FAIL reset_mid_held got=%b want=%b", outv, v_fetch());
        end
        rst = 1'b0;
        sb.push_back(v_fetch()); sb.push_back(v_decode()); sb.push_back(v_a_imm());
        sb.push_back(v_mem_rd()); sb.push_back(v_mem_wb(2'd3));
        while (sb.size() != 0) begin
            exp = sb.pop_front();
            @(negedge clk);
            n_cmp++;
            if (outv !== exp) begin
                n_err++; $display("FAIL reset_mid_post got=%b want=%b", outv, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [17:0] exp;
        inst = 32'hFFFFFFFF;
        sb.push_back(v_fetch()); sb.push_back(v_decode());
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 22; i++) sb.push_back(v_halt());
`else
        sb.push_back(v_pc_inc()); sb.push_back(v_fetch());
`endif
        while (sb.size() != 0) begin
            exp = sb.pop_front();
            @(negedge clk);
            n_cmp++;
            if (outv !== exp) begin
                n_err++; $display("FAIL illegal got=%b want=%b", outv, exp);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (outv !== v_fetch()) begin
            n_err++; $display("FAIL illegal_reset got=%b want=%b", outv, v_fetch());
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_mem();
        test_branch();
        test_jump();
        test_reset_mid();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
